clkgen_div_n: RTL and testbench

//  N-channel programmable clock-enable/divided-clock generator driven from one PLL output clock.
//  - Per channel: runtime-reprogrammable integer divisor and phase offset.
//  - Divisor and phase change glitch-free; a sync strobe realigns all channels.
//  - Lock indicator stays low until outputs are stable.
//  - Sits after the fixed-ratio PLL wrapper; lets SoC logic derive video/UART/SPI rates without new PLL builds.

---
 rtl/clkgen_pkg.sv | 22 ++
 rtl/clkgen_div_ch.sv | 79 +++++++
 rtl/clkgen_div_n.sv | 83 ++++++++
 tb/tb_clkgen_div_n.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared config record, divisor clamp and lock-counter sizing for clkgen_div_n
package clkgen_pkg;
    localparam int DIV_MIN    = 2;
    localparam int CFG_CH_W   = 4;
    localparam int CFG_DIV_W  = 32;
    localparam int CFG_FRAC_W = 16;

    typedef struct packed {
        logic [CFG_CH_W-1:0]   ch;
        logic [CFG_DIV_W-1:0]  div;
        logic [CFG_DIV_W-1:0]  phase;
        logic [CFG_FRAC_W-1:0] frac;
    } cfg_t;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
    endfunction

    function automatic int lock_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/clkgen_div_ch.sv
// clkgen_div_ch: one divided-clock channel; fractional accumulator built only with CLKGEN_FRAC_EN
module clkgen_div_ch
    import clkgen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              load_strobe,
    input  logic              sync,
    input  logic [DIV_W-1:0]  new_div,
    input  logic [DIV_W-1:0]  new_phase,
    input  logic [FRAC_W-1:0] new_frac,
    output logic              outclk,
    output logic              outen,
    output logic              wrap_pending_ok
);
    localparam int CW = DIV_W + 1;

    logic [CW-1:0]    cnt_q, cnt_d, dcur_q, dcur_d;
    logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d;
    logic             outclk_q, outclk_d, outen_q, outen_d;
    logic             carry;

    assign wrap_pending_ok = cnt_q == dcur_q - CW'(1);
    assign outclk          = outclk_q;
    assign outen           = outen_q;

`ifdef CLKGEN_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d, acc_q, acc_d;
    always_comb begin
        frac_d         = load_strobe ? new_frac : frac_q;
        {carry, acc_d} = sync ? '0 : wrap_pending_ok ? {1'b0, acc_q} + {1'b0, frac_d} : {1'b0, acc_q};
    end
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q <= '0;
            acc_q  <= '0;
        end else begin
            frac_q <= frac_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^new_frac;
    assign carry       = 1'b0;
`endif

    // the next period's length is fixed only at wrap or sync, so reprogramming never cuts a period short
    always_comb begin
        div_d    = load_strobe ? DIV_W'(clamp_div(32'(new_div))) : div_q;
        ph_d     = load_strobe ? new_phase : ph_q;
        cnt_d    = sync ? {1'b0, ph_d % div_d} : wrap_pending_ok ? '0 : cnt_q + CW'(1);
        dcur_d   = (sync || wrap_pending_ok) ? {1'b0, div_d} + CW'(carry) : dcur_q;
        outclk_d = cnt_d < (dcur_d >> 1);
        outen_d  = cnt_d == '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dcur_q   <= CW'(DEFAULT_DIV);
            div_q    <= DIV_W'(DEFAULT_DIV);
            ph_q     <= '0;
            outclk_q <= 1'b0;
            outen_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dcur_q   <= dcur_d;
            div_q    <= div_d;
            ph_q     <= ph_d;
            outclk_q <= outclk_d;
            outen_q  <= outen_d;
        end
    end
endmodule

// File: rtl/clkgen_div_n.sv
// clkgen_div_n: N-channel programmable divided-clock generator (fractional mode via CLKGEN_FRAC_EN)
module clkgen_div_n
    import clkgen_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 64,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              sync,
    output logic [N_CH-1:0]   outclk,
    output logic [N_CH-1:0]   outen,
    output logic              locked
);
    localparam int LW = lock_w(LOCK_CYCLES);

    cfg_t            pend_q, pend_d;
    logic            pend_v_q, pend_v_d, rdy_q, rdy_d, locked_q, locked_d, accept;
    logic [LW-1:0]   lock_q, lock_d;
    logic [N_CH-1:0] wrap_ok, load;
    logic            unused_pend;

    assign cfg_ready   = rdy_q;
    assign locked      = locked_q;
    assign unused_pend = ^pend_q;

    // out-of-range channels complete the handshake but never become pending
    always_comb begin
        accept   = cfg_valid && rdy_q;
        pend_d   = accept ? '{ch: CFG_CH_W'(cfg_ch), div: CFG_DIV_W'(cfg_div),
                              phase: CFG_DIV_W'(cfg_phase), frac: CFG_FRAC_W'(cfg_frac)} : pend_q;
        pend_v_d = accept ? (32'(cfg_ch) < N_CH) : pend_v_q && !(|load);
        rdy_d    = !pend_v_d;
        lock_d   = (accept || sync) ? LW'(LOCK_CYCLES) : (lock_q != '0) ? lock_q - LW'(1) : lock_q;
        locked_d = (lock_d == '0) && !pend_v_d;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            rdy_q    <= 1'b0;
            lock_q   <= LW'(LOCK_CYCLES);
            locked_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            rdy_q    <= rdy_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign load[i] = pend_v_q && (CH_W'(pend_q.ch) == CH_W'(i)) && wrap_ok[i];
        clkgen_div_ch #(
            .DIV_W(DIV_W),
            .FRAC_W(FRAC_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .refclk(refclk),
            .rst_n(rst_n),
            .load_strobe(load[i]),
            .sync(sync),
            .new_div(DIV_W'(pend_q.div)),
            .new_phase(DIV_W'(pend_q.phase)),
            .new_frac(FRAC_W'(pend_q.frac)),
            .outclk(outclk[i]),
            .outen(outen[i]),
            .wrap_pending_ok(wrap_ok[i])
        );
    end
endmodule

// File: tb/tb_clkgen_div_n.sv
// tb_clkgen_div_n: directed self-checking bench for clkgen_div_n (honours CLKGEN_FRAC_EN)
module tb_clkgen_div_n;
`ifdef CLKGEN_FRAC_EN
    localparam int EXP_TOT = 1152, EXP_G2 = 5;
`else
    localparam int EXP_TOT = 1024, EXP_G2 = 4;
`endif

    logic       refclk = 1'b0, rst_n = 1'b1, cfg_valid = 1'b0, sync = 1'b0;
    logic       cfg_ready, locked;
    logic [1:0] cfg_ch = '0;
    logic [15:0] cfg_div = '0, cfg_phase = '0;
    logic [7:0] cfg_frac = '0;
    logic [2:0] outclk, outen;
    int         total = 0, bad = 0;

    clkgen_div_n dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_frac(cfg_frac),
        .sync(sync), .outclk(outclk), .outen(outen), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        cfg_valid = 1'b0;
        sync      = 1'b0;
        #3 rst_n  = 1'b0;
        #1 chk("rst_async", {outclk, outen, locked, cfg_ready}, 0);
        repeat (5) tick;
        chk("rst_hold", {outclk, outen, locked, cfg_ready}, 0);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int dv, input int ph, input int fr);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 300) begin tick; n++; end
        chk("wr_wait_ready", n < 300, 1);
        cfg_ch = 2'(ch); cfg_div = 16'(dv); cfg_phase = 16'(ph); cfg_frac = 8'(fr);
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 300) begin tick; n++; end
        chk("wr_wait_apply", n < 300, 1);
    endtask

    task automatic measure_period(input int ch, output int p);
        int n = 0;
        while (outen[ch] !== 1'b1 && n < 100) begin tick; n++; end
        chk("per_wait", n < 100, 1);
        p = 0;
        do begin tick; p++; end while (outen[ch] !== 1'b1 && p < 100);
    endtask

    task automatic check_phases(input string tag);
        logic [2:0] exp_clk [4];
        logic [2:0] exp_en [4];
        exp_clk = '{3'b011, 3'b101, 3'b100, 3'b010};
        exp_en  = '{3'b001, 3'b100, 3'b000, 3'b010};
        sync = 1'b1;
        tick;
        sync = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk({tag, "_clk"}, outclk, exp_clk[j]);
            chk({tag, "_en"}, outen, exp_en[j]);
            tick;
        end
    endtask

    initial begin
        int p, n, tot, k, g1, g2;
        // T1: reset, D=2 toggling, lock after 64 cycles
        tick;
        do_reset;
        tick;
        chk("t1_ready_first", {cfg_ready, locked, outclk}, 5'b10000);
        tick;
        chk("t1_d2_high", {outclk, outen}, 6'b111111);
        tick;
        chk("t1_d2_low", {outclk, outen}, 6'b000000);
        repeat (60) tick;
        chk("t1_lock_63", locked, 0);
        tick;
        chk("t1_lock_64", locked, 1);
        // T2: ch1 to D=5 mid-period
        cfg_ch = 2'd1; cfg_div = 16'd5; cfg_phase = '0; cfg_frac = '0; cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("t2_accept", {cfg_ready, locked, outclk[1]}, 3'b000);
        tick;
        chk("t2_apply", {cfg_ready, outclk[1], outen[1]}, 3'b111);
        for (int j = 1; j < 10; j++) begin
            tick;
            chk("t2_ch1_shape", outclk[1], (j % 5) < 2);
            chk("t2_ch0_keep", outclk[0], (j % 2) == 0);
        end
        repeat (53) tick;
        chk("t2_relock_63", locked, 0);
        tick;
        chk("t2_relock_64", locked, 1);
        // T3: phase alignment, repeated across syncs
        do_reset;
        cfg_write(0, 4, 0, 0);
        cfg_write(1, 4, 1, 0);
        cfg_write(2, 4, 3, 0);
        check_phases("t3_sync1");
        repeat (3) tick;
        check_phases("t3_sync2");
        repeat (6) tick;
        check_phases("t3_sync3");
        // T4: sync coincident with pending apply on ch0
        sync = 1'b1;
        tick;
        sync = 1'b0;
        cfg_ch = 2'd0; cfg_div = 16'd6; cfg_phase = 16'd6; cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        repeat (2) tick;
        chk("t4_pending", cfg_ready, 0);
        sync = 1'b1;
        tick;
        sync = 1'b0;
        chk("t4_applied", {cfg_ready, outen[0]}, 2'b11);
        for (int j = 0; j < 12; j++) begin
            chk("t4_d6_shape", outclk[0], (j % 6) < 3);
            tick;
        end
        // T5: D=0 clamps, out-of-range channel only reloads lock
        do_reset;
        cfg_write(2, 4, 0, 0);
        cfg_write(2, 0, 0, 0);
        measure_period(2, p);
        chk("t5_clamp_period", p, 2);
        chk("t5_clamp_high", outclk[2], 1);
        tick;
        chk("t5_clamp_low", outclk[2], 0);
        n = 0;
        while (locked !== 1'b1 && n < 300) begin tick; n++; end
        chk("t5_locked_wait", n < 300, 1);
        chk("t5_ready_before", cfg_ready, 1);
        cfg_ch = 2'd3; cfg_div = 16'd9; cfg_phase = '0; cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("t5_lock_drop", locked, 0);
        repeat (63) tick;
        chk("t5_lock_63", locked, 0);
        tick;
        chk("t5_lock_64", locked, 1);
        for (int c = 0; c < 3; c++) begin
            measure_period(c, p);
            chk("t5_unchanged", p, 2);
        end
        // T6: fractional divisor D=4 F=0x80
        do_reset;
        cfg_write(0, 4, 0, 128);
        sync = 1'b1;
        tick;
        sync = 1'b0;
        chk("t6_sync_outen", outen[0], 1);
        p = 0;
        do begin tick; p++; end while (outen[0] !== 1'b1 && p < 100);
        chk("t6_first_period", p, 4);
        tot = 0; k = 0; g1 = 0; g2 = 0;
        while (k < 256 && tot < 4000) begin
            tick;
            tot++;
            if (outen[0]) begin
                k++;
                if (k == 1) g1 = tot;
                if (k == 2) g2 = tot - g1;
            end
        end
        chk("t6_gap1", g1, 4);
        chk("t6_gap2", g2, EXP_G2);
        chk("t6_total", tot, EXP_TOT);
        do_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
